keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 matrix keypad (Pmod KYPD layout) and converts key presses into the 4-bit `decode` codes consumed by the game FSM. The 1–4 keys select operands and the A–D keys select operators. The block drives one column low at a time and samples the active-low row lines through a synchronizer. It debounces whole-keypad scan frames and emits a single-cycle `decode_valid` strobe per debounced press, so a held key is acted on exactly once. It sits between the keypad pins and the game FSM.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven; minimum 4.
- `DEBOUNCE`, default 4: number of consecutive identical frames required before a new key state is accepted; minimum 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `row`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col`  out  4  keypad column drive, active-low, exactly one bit low at all times.
- `decode`  out  4  code of the last accepted key; valid when `decode_valid`, held otherwise.
- `decode_valid`  out  1  one-cycle strobe marking a newly accepted key.
- `pressed`  out  1  level output, high while a debounced key is held.

## Operation
- Key map, row r / column c to code:
  - r0: 1,2,3,A → 0001, 0010, 0011, 1010.
  - r1: 4,5,6,B → 0100, 0101, 0110, 1011.
  - r2: 7,8,9,C → 0111, 1000, 1001, 1100.
  - r3: 0,F,E,D → 0000, 1111, 1110, 1101.
- `row` passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - Divider counts 0..SCAN_DIV-1.
  - On the last count, synchronized rows are sampled for the current column and `col` advances 0→1→2→3→0, giving 1110→1101→1011→0111→1110.
- Frame accumulation:
  - Result kinds: NONE, KEY(code), MULTI (two or more keys).
  - A column sample with exactly one low row contributes KEY. Two or more low bits within a frame, across any rows and columns, make the frame MULTI (see Configuration).
- Frame evaluation, at the end of column 3:
  - The result is compared with `cand`.
  - If equal, `cnt` saturates-increments to DEBOUNCE. Otherwise `cand` takes the result and `cnt` becomes 1.
  - When `cnt` reaches DEBOUNCE and `cand` differs from `stable`, `stable` takes `cand`.
- Stable-state transitions:
  - NONE→KEY(k) or KEY(j)→KEY(k) with k≠j: `decode`=k, `decode_valid` pulses for one cycle, `pressed`=1.
  - KEY→NONE: `pressed`=0, no strobe, `decode` holds.
  - MULTI is never reported. It counts as NONE for `stable` and `pressed`.
- Key 0 legitimately encodes as 0000. Consumers must qualify `decode` with `decode_valid`.

## Timing
- Reset values: `col`=1110, `decode`=0000, `decode_valid`=0, `pressed`=0. Divider, `cnt`, `cand`=NONE and `stable`=NONE are all cleared.
- Frame length is 4·SCAN_DIV cycles.
- Press latency:
  - A key held from before a frame start gives `decode_valid` at the end of the DEBOUNCE-th full frame, plus 1 cycle for the registered output.
  - Worst case: (DEBOUNCE+1)·4·SCAN_DIV + 3 cycles, including the synchronizer.
- Release latency: `pressed` falls within (DEBOUNCE+1)·4·SCAN_DIV + 3 cycles.
- A bounce shorter than DEBOUNCE frames never changes `stable`.
- All outputs are registered. `decode` updates in the same cycle `decode_valid` rises.
- `rst` mid-frame: next cycle restarts at column 0 with divider 0, drops any pending strobe and clears `pressed`. A key still held after reset is re-reported once after debouncing.
- `cnt` saturates and never wraps; holding a key indefinitely produces no repeat strobes.

## Configuration
- `KEYPAD_MULTI_REJECT_EN` defined: any frame with two or more low row samples is MULTI and treated as NONE (ghost-key rejection).
- Not defined: MULTI does not exist. The first low sample in scan order (column 0 first, then row 0 first) gives the frame's KEY and later ones are ignored.

## Test plan
- Bench setup: SCAN_DIV=4, DEBOUNCE=2, keypad model pulling `row[r]` low while `col[c]` is low and key (r,c) is held.
- Reset, no keys: `col` cycles 1110,1101,1011,0111 every 4 clocks; `decode_valid` never asserts; `decode`=0000; `pressed`=0.
- Hold key "3" (r0,c2) for 10 frames: exactly one `decode_valid` with `decode`=0011 within 51 cycles; `pressed`=1 until 51 cycles after release.
- Hold "A", toggling for 1 frame every 3 frames as bounce: no strobe for the 1-frame glitches; a single 1010 strobe once 2 stable frames accumulate.
- Slide from "1" to "D" without release: strobes 0001 then 1101; `pressed` stays 1.
- Hold "2" and "B" together: with the macro, no strobe and `pressed`=0; without it, a single 0010 strobe.
- Assert `rst` mid-frame while "4" is held: outputs return to reset values the next cycle; one 0100 strobe follows after re-debounce.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad pin and decoded-key bundle between the scanner, the keypad pins and the game FSM.
// No latency of its own; plain wires.
// No backpressure: decode_valid is a one-cycle strobe the consumer must take when it fires.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] decode;
    logic       decode_valid;
    logic       pressed;

    // Scanner side: samples rows, drives columns and the decoded key.
    modport master (
        input  row,
        output col, decode, decode_valid, pressed
    );

    // Keypad/consumer side.
    modport slave (
        output row,
        input  col, decode, decode_valid, pressed
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column sequencer, frame accumulation, frame debounce, one strobe per accepted key.
// Latency: key accepted after DEBOUNCE identical frames of 4*SCAN_DIV cycles each, plus sync and output register.
// No backpressure; KEYPAD_MULTI_REJECT_EN turns frames with 2+ low samples into "no key" (ghost rejection).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    // Frame result kinds; MULTI only lives inside the per-frame accumulator.
    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_KEY   = 2'd1;
`ifdef KEYPAD_MULTI_REJECT_EN
    localparam logic [1:0] KIND_MULTI = 2'd2;
`endif

    logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       acc_kind_q, acc_kind_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic [1:0]       cand_kind_q, cand_kind_d;
    logic [3:0]       cand_code_q, cand_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       stable_kind_q, stable_kind_d;
    logic [3:0]       stable_code_q, stable_code_d;
    logic [3:0]       decode_q, decode_d;
    logic             decode_valid_q, decode_valid_d;
    logic             pressed_q, pressed_d;

    logic             last_cnt;
    logic [3:0]       low;
    logic [2:0]       n_low;
    logic [1:0]       first_r;
    logic [3:0]       samp_code;
    logic [1:0]       acc_kind_m, res_kind;
    logic [3:0]       acc_code_m, res_code;

    // Pmod KYPD key map: row r, column c to game code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Next-state logic: sync, sequencer, per-column sampling, end-of-frame debounce and output update.
    always_comb begin
        row_s1_d       = kp.row;
        row_s2_d       = row_s1_q;
        div_d          = div_q;
        col_idx_d      = col_idx_q;
        col_d          = col_q;
        acc_kind_d     = acc_kind_q;
        acc_code_d     = acc_code_q;
        cand_kind_d    = cand_kind_q;
        cand_code_d    = cand_code_q;
        cnt_d          = cnt_q;
        stable_kind_d  = stable_kind_q;
        stable_code_d  = stable_code_q;
        decode_d       = decode_q;
        decode_valid_d = 1'b0;
        pressed_d      = pressed_q;
        acc_kind_m     = acc_kind_q;
        acc_code_m     = acc_code_q;
        res_kind       = KIND_NONE;
        res_code       = 4'h0;

        last_cnt = (div_q == DIV_W'(SCAN_DIV - 1));
        low      = ~row_s2_q;
        n_low    = 3'd0;
        first_r  = 2'd0;
        // Lowest-numbered low row wins so scan order is row 0 first.
        for (int i = 3; i >= 0; i--) begin
            n_low = n_low + {2'b00, low[i]};
            if (low[i]) first_r = 2'(i);
        end
        samp_code = key_code(first_r, col_idx_q);

        if (last_cnt) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};

`ifdef KEYPAD_MULTI_REJECT_EN
            // Any second low sample in the frame poisons it.
            if (n_low != 3'd0) begin
                if (acc_kind_q == KIND_NONE && n_low == 3'd1) begin
                    acc_kind_m = KIND_KEY;
                    acc_code_m = samp_code;
                end else begin
                    acc_kind_m = KIND_MULTI;
                end
            end
`else
            // First key seen in scan order owns the frame.
            if (n_low != 3'd0 && acc_kind_q == KIND_NONE) begin
                acc_kind_m = KIND_KEY;
                acc_code_m = samp_code;
            end
`endif

            if (col_idx_q == 2'd3) begin
                // MULTI collapses to NONE here, so cand/stable only ever hold NONE or KEY.
                if (acc_kind_m == KIND_KEY) begin
                    res_kind = KIND_KEY;
                    res_code = acc_code_m;
                end
                acc_kind_d = KIND_NONE;
                acc_code_d = 4'h0;

                if ({res_kind, res_code} == {cand_kind_q, cand_code_q}) begin
                    if (cnt_q != CNT_W'(DEBOUNCE)) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cand_kind_d = res_kind;
                    cand_code_d = res_code;
                    cnt_d       = CNT_W'(1);
                end

                if (cnt_d == CNT_W'(DEBOUNCE) &&
                    {cand_kind_d, cand_code_d} != {stable_kind_q, stable_code_q}) begin
                    stable_kind_d = cand_kind_d;
                    stable_code_d = cand_code_d;
                    pressed_d     = (cand_kind_d == KIND_KEY);
                    if (cand_kind_d == KIND_KEY) begin
                        decode_d       = cand_code_d;
                        decode_valid_d = 1'b1;
                    end
                end
            end else begin
                acc_kind_d = acc_kind_m;
                acc_code_d = acc_code_m;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q       <= 4'hF;
            row_s2_q       <= 4'hF;
            div_q          <= '0;
            col_idx_q      <= 2'd0;
            col_q          <= 4'b1110;
            acc_kind_q     <= KIND_NONE;
            acc_code_q     <= 4'h0;
            cand_kind_q    <= KIND_NONE;
            cand_code_q    <= 4'h0;
            cnt_q          <= '0;
            stable_kind_q  <= KIND_NONE;
            stable_code_q  <= 4'h0;
            decode_q       <= 4'h0;
            decode_valid_q <= 1'b0;
            pressed_q      <= 1'b0;
        end else begin
            row_s1_q       <= row_s1_d;
            row_s2_q       <= row_s2_d;
            div_q          <= div_d;
            col_idx_q      <= col_idx_d;
            col_q          <= col_d;
            acc_kind_q     <= acc_kind_d;
            acc_code_q     <= acc_code_d;
            cand_kind_q    <= cand_kind_d;
            cand_code_q    <= cand_code_d;
            cnt_q          <= cnt_d;
            stable_kind_q  <= stable_kind_d;
            stable_code_q  <= stable_code_d;
            decode_q       <= decode_d;
            decode_valid_q <= decode_valid_d;
            pressed_q      <= pressed_d;
        end
    end

    assign kp.col          = col_q;
    assign kp.decode       = decode_q;
    assign kp.decode_valid = decode_valid_q;
    assign kp.pressed      = pressed_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 and a keypad matrix model.
// Checks reset, column sequence, press/release latency, bounce, slide, multi-key and mid-frame reset.
// Expectations for the two-key case follow KEYPAD_MULTI_REJECT_EN.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;     // bit r*4+c set while key (r,c) is held
    logic [3:0]  row_drv;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    logic [3:0] last_code = 4'h0;
    bit watch_press = 1'b0;
    bit press_drop = 1'b0;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Keypad model: row r is pulled low while its column is driven low and key (r,c) is held.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col[c]) row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    // Strobe and pressed monitor, sampled shortly after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (kif.decode_valid === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            last_code  = kif.decode;
        end
        if (watch_press && kif.pressed !== 1'b1) press_drop = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) for the strobe count to reach target.
    task automatic wait_strobes(input int target, input int bound);
        for (int i = 0; i < bound && strobe_cnt < target; i++) @(negedge clk);
    endtask

    // Wait (bounded) for pressed to fall.
    task automatic wait_release(input int bound);
        for (int i = 0; i < bound && kif.pressed !== 1'b0; i++) @(negedge clk);
    endtask

    logic [3:0] col_exp [4];

    initial begin
        col_exp[0] = 4'b1110; col_exp[1] = 4'b1101; col_exp[2] = 4'b1011; col_exp[3] = 4'b0111;

        // Reset state.
        cycles(3);
        check("rst_col", {28'h0, kif.col}, 32'hE);
        check("rst_decode", {28'h0, kif.decode}, 32'h0);
        check("rst_dv", {31'h0, kif.decode_valid}, 32'h0);
        check("rst_pressed", {31'h0, kif.pressed}, 32'h0);
        rst = 1'b0;

        // Column sequence, 4 clocks per column.
        for (int i = 0; i < 16; i++) begin
            check("col_seq", {28'h0, kif.col}, {28'h0, col_exp[(i/4)%4]});
            @(negedge clk);
        end
        cycles(32);
        check("idle_strobes", strobe_cnt, 0);
        check("idle_pressed", {31'h0, kif.pressed}, 32'h0);
        check("idle_decode", {28'h0, kif.decode}, 32'h0);

        // Hold "3" (r0,c2) for 10 frames.
        strobe_cnt = 0;
        keys = 16'h0004;
        wait_strobes(1, 51);
        check("k3_strobe", strobe_cnt, 1);
        check("k3_code", {28'h0, last_code}, 32'h3);
        check("k3_pressed", {31'h0, kif.pressed}, 32'h1);
        cycles(110);
        check("k3_no_repeat", strobe_cnt, 1);
        check("k3_still_pressed", {31'h0, kif.pressed}, 32'h1);
        keys = 16'h0;
        wait_release(51);
        check("k3_release", {31'h0, kif.pressed}, 32'h0);
        check("k3_decode_hold", {28'h0, kif.decode}, 32'h3);
        check("k3_release_no_strobe", strobe_cnt, 1);
        cycles(40);

        // Bounce on "A" (r0,c3): 2 frames held, 1 frame released, repeated.
        strobe_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            keys = 16'h0008;
            cycles(32);
            if (p == 0) begin
                cycles(3);
                watch_press = (strobe_cnt == 1);
                press_drop  = 1'b0;
            end
            keys = 16'h0;
            cycles(16);
        end
        keys = 16'h0008;
        cycles(16);
        check("bounce_strobes", strobe_cnt, 1);
        check("bounce_code", {28'h0, last_code}, 32'hA);
        check("bounce_watch", {31'h0, watch_press}, 32'h1);
        check("bounce_no_drop", {31'h0, press_drop}, 32'h0);
        watch_press = 1'b0;
        keys = 16'h0;
        wait_release(51);
        check("bounce_release", {31'h0, kif.pressed}, 32'h0);
        cycles(40);

        // Slide "1" (r0,c0) to "D" (r3,c3) without release.
        strobe_cnt = 0;
        keys = 16'h0001;
        wait_strobes(1, 51);
        check("slide_first", {28'h0, last_code}, 32'h1);
        cycles(2);
        watch_press = 1'b1;
        press_drop  = 1'b0;
        keys = 16'h8000;
        wait_strobes(2, 51);
        check("slide_strobes", strobe_cnt, 2);
        check("slide_second", {28'h0, last_code}, 32'hD);
        cycles(20);
        check("slide_no_drop", {31'h0, press_drop}, 32'h0);
        watch_press = 1'b0;
        keys = 16'h0;
        wait_release(51);
        check("slide_release", {31'h0, kif.pressed}, 32'h0);
        cycles(40);

        // "2" (r0,c1) and "B" (r1,c3) together.
        strobe_cnt = 0;
        keys = 16'h0082;
        cycles(96);
`ifdef KEYPAD_MULTI_REJECT_EN
        check("multi_strobes", strobe_cnt, 0);
        check("multi_pressed", {31'h0, kif.pressed}, 32'h0);
`else
        check("multi_strobes", strobe_cnt, 1);
        check("multi_code", {28'h0, last_code}, 32'h2);
        check("multi_pressed", {31'h0, kif.pressed}, 32'h1);
`endif
        keys = 16'h0;
        wait_release(51);
        check("multi_release", {31'h0, kif.pressed}, 32'h0);
        cycles(40);

        // Mid-frame reset while "4" (r1,c0) is held.
        strobe_cnt = 0;
        keys = 16'h0010;
        wait_strobes(1, 51);
        check("k4_first", {28'h0, last_code}, 32'h4);
        cycles(5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_col", {28'h0, kif.col}, 32'hE);
        check("mid_rst_decode", {28'h0, kif.decode}, 32'h0);
        check("mid_rst_dv", {31'h0, kif.decode_valid}, 32'h0);
        check("mid_rst_pressed", {31'h0, kif.pressed}, 32'h0);
        strobe_cnt = 0;
        rst = 1'b0;
        wait_strobes(1, 51);
        check("k4_rereport", strobe_cnt, 1);
        check("k4_rereport_code", {28'h0, last_code}, 32'h4);
        cycles(64);
        check("k4_once", strobe_cnt, 1);
        keys = 16'h0;
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
